// File: rtl/vram_bus_responder_pkg.sv
// Shared types and bus constants for the video-board bus responder.
package video_bus_pkg;

  // Responder cycle states.
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ARB,
    ACCESS,
    RDWAIT,
    ACK
  } resp_state_t;

  // R_b_Vs_W encoding.
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

endpackage

// File: rtl/vram_bus_responder_if.sv
// CPU bus and local RAM port seen by the VRAM responder.
interface vram_bus_responder_if #(
  parameter int ADDR_W = 12
);
  // CPU side
  logic [22:0]       A;
  logic [15:0]       D_in;
  logic              AS_b;
  logic              UDS_b;
  logic              LDS_b;
  logic              R_b_Vs_W;
  logic              SEL_b;
  logic              VID_SLOT;
  logic              DTACK_b;
  logic [15:0]       D_out;
  logic              DOE;
  // RAM side
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [15:0]       MEM_WDATA;
  logic              MEM_WE_H;
  logic              MEM_WE_L;
  logic              MEM_RE;
  logic [15:0]       MEM_RDATA;

  modport slave (
    input  A, D_in, AS_b, UDS_b, LDS_b, R_b_Vs_W, SEL_b, VID_SLOT, MEM_RDATA,
    output DTACK_b, D_out, DOE, MEM_ADDR, MEM_WDATA, MEM_WE_H, MEM_WE_L, MEM_RE
  );

  modport master (
    output A, D_in, AS_b, UDS_b, LDS_b, R_b_Vs_W, SEL_b, VID_SLOT, MEM_RDATA,
    input  DTACK_b, D_out, DOE, MEM_ADDR, MEM_WDATA, MEM_WE_H, MEM_WE_L, MEM_RE
  );

endinterface

// File: rtl/vram_bus_responder_cycle_counter.sv
// 4-bit loadable down-counter; done flags the last counted cycle.
module cycle_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] count;

  // A load of N makes done rise on the Nth cycle after the load edge.
  assign done = (count <= 4'd1);

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                count <= 4'd0;
    else if (load)             count <= load_val;
    else if (en && count != 0) count <= count - 4'd1;
  end

endmodule

// File: rtl/vram_bus_responder.sv
// VRAM bus-slave responder: wait states, video-slot arbitration, one RAM
// access per CPU cycle, registered DTACK_b / read data back to the CPU.
module vram_bus_responder
  import video_bus_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1,
  parameter int MEM_LAT     = 1
) (
  input  logic MCKR,
  input  logic SYSRES_b,
  vram_bus_responder_if.slave bus
);

  localparam logic [3:0] WS_CNT  = 4'(WAIT_STATES);
  localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

  resp_state_t state, next_state;
  logic        armed;
  logic        req;
  logic        dir;
  logic [1:0]  mask;
  logic        cnt_load;
  logic        cnt_en;
  logic        cnt_done;
  logic [3:0]  cnt_val;
  logic        unused_a;

  // Upper CPU address bits are decoded externally into SEL_b.
  assign unused_a = ^bus.A[22:ADDR_W];

  // armed blocks a retrigger until AS_b has been seen high after a cycle.
  assign req = armed && !bus.AS_b && !bus.SEL_b && (!bus.UDS_b || !bus.LDS_b);

  cycle_counter u_cnt (
    .clk      (MCKR),
    .rst_n    (SYSRES_b),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  // State register.
  always_ff @(posedge MCKR or negedge SYSRES_b) begin
    if (!SYSRES_b) state <= IDLE;
    else           state <= next_state;
  end

  // Next state and counter control; AS_b high aborts any pre-ACK state.
  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_val    = WS_CNT;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            next_state = WAIT;
            cnt_load   = 1'b1;
          end else begin
            next_state = ARB;
          end
        end
      end
      WAIT: begin
        if (bus.AS_b)      next_state = IDLE;
        else if (cnt_done) next_state = ARB;
        else               cnt_en     = 1'b1;
      end
      ARB: begin
        if (bus.AS_b)          next_state = IDLE;
        else if (!bus.VID_SLOT) next_state = ACCESS;
      end
      ACCESS: begin
        // A write strobe issued this cycle stands even if AS_b rose.
        if (bus.AS_b)          next_state = IDLE;
        else if (dir == WRITE) next_state = ACK;
        else begin
          next_state = RDWAIT;
          cnt_load   = 1'b1;
          cnt_val    = LAT_CNT;
        end
      end
      RDWAIT: begin
        if (bus.AS_b)      next_state = IDLE;
        else if (cnt_done) next_state = ACK;
        else               cnt_en     = 1'b1;
      end
      ACK: begin
        if (bus.AS_b) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch address, data, byte lanes and direction at the request edge.
  always_ff @(posedge MCKR or negedge SYSRES_b) begin
    if (!SYSRES_b) begin
      bus.MEM_ADDR  <= '0;
      bus.MEM_WDATA <= '0;
      mask          <= 2'b00;
      dir           <= WRITE;
      armed         <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        bus.MEM_ADDR  <= bus.A[ADDR_W-1:0];
        bus.MEM_WDATA <= bus.D_in;
        mask          <= {~bus.UDS_b, ~bus.LDS_b};
        dir           <= bus.R_b_Vs_W;
        armed         <= 1'b0;
      end else if (bus.AS_b) begin
        armed <= 1'b1;
      end
    end
  end

  // Registered strobes and acknowledge, decoded from the state being entered.
  always_ff @(posedge MCKR or negedge SYSRES_b) begin
    if (!SYSRES_b) begin
      bus.MEM_WE_H <= 1'b0;
      bus.MEM_WE_L <= 1'b0;
      bus.MEM_RE   <= 1'b0;
      bus.DTACK_b  <= 1'b1;
      bus.DOE      <= 1'b0;
    end else begin
      bus.MEM_WE_H <= (next_state == ACCESS) && (dir == WRITE) && mask[1];
      bus.MEM_WE_L <= (next_state == ACCESS) && (dir == WRITE) && mask[0];
      bus.MEM_RE   <= (next_state == ACCESS) && (dir == READ);
      bus.DTACK_b  <= !(next_state == ACK);
      bus.DOE      <= (next_state == ACK) && (dir == READ);
    end
  end

  // Read data captured on the last RDWAIT edge; held across aborts.
  always_ff @(posedge MCKR or negedge SYSRES_b) begin
    if (!SYSRES_b)                                  bus.D_out <= '0;
    else if (state == RDWAIT && next_state == ACK) bus.D_out <= bus.MEM_RDATA;
  end

endmodule

// File: tb/tb_vram_bus_responder.sv
// Self-checking bench for vram_bus_responder (WAIT_STATES=1, MEM_LAT=2).
module tb_vram_bus_responder;
  import video_bus_pkg::*;

  localparam int WS  = 1;
  localparam int LAT = 2;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    logic        we_h;
    logic        we_l;
    logic        rd;
    int          strobe_rel;
    int          ack_rel;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc     = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] ram_word = 16'h0000;
  logic [15:0] rd_p0    = 16'hDEAD;
  logic [15:0] rd_p1    = 16'hDEAD;
  exp_t        exp_q[$];

  vram_bus_responder_if #(.ADDR_W(12)) bus();

  vram_bus_responder #(.ADDR_W(12), .WAIT_STATES(WS), .MEM_LAT(LAT)) dut (
    .MCKR     (clk),
    .SYSRES_b (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data appears LAT cycles after the MEM_RE cycle, garbage otherwise.
  always @(posedge clk) begin
    rd_p0 <= bus.MEM_RE ? ram_word : 16'hDEAD;
    rd_p1 <= rd_p0;
  end
  assign bus.MEM_RDATA = rd_p1;

  task automatic bus_idle();
    bus.AS_b = 1'b1; bus.UDS_b = 1'b1; bus.LDS_b = 1'b1; bus.SEL_b = 1'b1;
    bus.R_b_Vs_W = READ; bus.VID_SLOT = 1'b0;
  endtask

  // One CPU cycle; called at a negedge, returns at the negedge after release.
  task automatic cpu_cycle(input logic [22:0] addr, input logic [15:0] wd,
                           input logic uds_n, input logic lds_n, input logic rd,
                           input int vid_hold, input string tag);
    exp_t e, got;
    int   edge0, rel, strobes;
    bit   acked, popped, stb;
    e.addr = addr[11:0]; e.data = rd ? ram_word : wd;
    e.we_h = !rd && !uds_n; e.we_l = !rd && !lds_n; e.rd = rd;
    e.strobe_rel = WS + 1 + vid_hold;
    e.ack_rel    = WS + 2 + vid_hold + (rd ? LAT : 0);
    exp_q.push_back(e);
    bus.A = addr; bus.D_in = wd; bus.UDS_b = uds_n; bus.LDS_b = lds_n;
    bus.R_b_Vs_W = rd ? READ : WRITE; bus.SEL_b = 1'b0; bus.AS_b = 1'b0;
    bus.VID_SLOT = (vid_hold > 0);
    edge0 = cyc + 1; strobes = 0; acked = 0; popped = 0;
    got = e;
    for (int i = 0; i < 40 && !acked; i++) begin
      @(negedge clk);
      rel = cyc - edge0;
      if (rel == 0) begin bus.A = ~addr; bus.D_in = ~wd; end
      if (vid_hold > 0 && rel == WS + vid_hold) bus.VID_SLOT = 1'b0;
      stb = bus.MEM_WE_H | bus.MEM_WE_L | bus.MEM_RE;
      if ((stb || !bus.DTACK_b) && !popped) begin got = exp_q.pop_front(); popped = 1; end
      if (stb) begin
        strobes++;
        if (strobes == 1) begin
          n_checks++;
          if (rel !== got.strobe_rel) begin n_fail++; $display("FAIL %s strobe_edge: got %0d expected %0d", tag, rel, got.strobe_rel); end
          n_checks++;
          if (bus.MEM_ADDR !== got.addr) begin n_fail++; $display("FAIL %s mem_addr: got %h expected %h", tag, bus.MEM_ADDR, got.addr); end
          n_checks++;
          if ({bus.MEM_WE_H, bus.MEM_WE_L, bus.MEM_RE} !== {got.we_h, got.we_l, got.rd}) begin
            n_fail++; $display("FAIL %s we_h/we_l/re: got %b expected %b", tag,
              {bus.MEM_WE_H, bus.MEM_WE_L, bus.MEM_RE}, {got.we_h, got.we_l, got.rd});
          end
          if (!got.rd) begin
            n_checks++;
            if (bus.MEM_WDATA !== got.data) begin n_fail++; $display("FAIL %s mem_wdata: got %h expected %h", tag, bus.MEM_WDATA, got.data); end
          end
        end
      end
      if (!bus.DTACK_b) begin
        acked = 1;
        n_checks++;
        if (rel !== got.ack_rel) begin n_fail++; $display("FAIL %s dtack_edge: got %0d expected %0d", tag, rel, got.ack_rel); end
        n_checks++;
        if (bus.DOE !== got.rd) begin n_fail++; $display("FAIL %s doe: got %b expected %b", tag, bus.DOE, got.rd); end
        n_checks++;
        if (strobes !== 1) begin n_fail++; $display("FAIL %s strobe_cycles: got %0d expected 1", tag, strobes); end
        if (got.rd) begin
          n_checks++;
          if (bus.D_out !== got.data) begin n_fail++; $display("FAIL %s d_out: got %h expected %h", tag, bus.D_out, got.data); end
        end
        bus_idle();
      end
    end
    if (!acked) begin
      n_checks++; n_fail++;
      $display("FAIL %s dtack_timeout: got none expected edge %0d", tag, e.ack_rel);
      if (!popped) void'(exp_q.pop_front());
      bus_idle();
    end
    @(negedge clk);
    n_checks++;
    if ({bus.DTACK_b, bus.DOE} !== 2'b10) begin n_fail++; $display("FAIL %s release dtack/doe: got %b expected 10", tag, {bus.DTACK_b, bus.DOE}); end
  endtask

  task automatic test_reset();
    bus_idle(); bus.A = '0; bus.D_in = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.DTACK_b, bus.DOE, bus.D_out} !== {1'b1, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL reset dtack/doe/dout: got %h expected %h", {bus.DTACK_b, bus.DOE, bus.D_out}, {1'b1, 1'b0, 16'h0});
    end
    n_checks++;
    if ({bus.MEM_ADDR, bus.MEM_WDATA, bus.MEM_WE_H, bus.MEM_WE_L, bus.MEM_RE} !== 31'h0) begin
      n_fail++; $display("FAIL reset mem_outputs: got %h expected 0", {bus.MEM_ADDR, bus.MEM_WDATA, bus.MEM_WE_H, bus.MEM_WE_L, bus.MEM_RE});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_word_write();
    cpu_cycle(23'h000123, 16'hBEEF, 1'b0, 1'b0, 1'b0, 0, "word_write");
  endtask

  task automatic test_byte_read();
    ram_word = 16'h5A5A;
    cpu_cycle(23'h000456, 16'h0000, 1'b1, 1'b0, 1'b1, 0, "byte_read");
  endtask

  task automatic test_vid_slot();
    cpu_cycle(23'h000789, 16'hC0DE, 1'b0, 1'b0, 1'b0, 4, "vid_slot_write");
  endtask

  task automatic test_abort_arb();
    int ns = 0, nd = 0;
    bus.A = 23'h000321; bus.D_in = 16'h1111; bus.UDS_b = 1'b0; bus.LDS_b = 1'b0;
    bus.R_b_Vs_W = WRITE; bus.SEL_b = 1'b0; bus.AS_b = 1'b0; bus.VID_SLOT = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.MEM_WE_H | bus.MEM_WE_L | bus.MEM_RE) ns++;
      if (!bus.DTACK_b) nd++;
      if (i == 3) begin bus.AS_b = 1'b1; bus.UDS_b = 1'b1; bus.LDS_b = 1'b1; end
      if (i == 5) bus.VID_SLOT = 1'b0;
    end
    n_checks++;
    if (ns !== 0) begin n_fail++; $display("FAIL abort_arb strobes: got %0d expected 0", ns); end
    n_checks++;
    if (nd !== 0) begin n_fail++; $display("FAIL abort_arb dtack_cycles: got %0d expected 0", nd); end
    bus_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_in_ack();
    bit acked = 0;
    ram_word = 16'h1357;
    bus.A = 23'h000777; bus.UDS_b = 1'b0; bus.LDS_b = 1'b0;
    bus.R_b_Vs_W = READ; bus.SEL_b = 1'b0; bus.AS_b = 1'b0; bus.VID_SLOT = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge clk);
      if (!bus.DTACK_b) acked = 1;
    end
    n_checks++;
    if ({acked, bus.DOE, bus.D_out} !== {1'b1, 1'b1, 16'h1357}) begin
      n_fail++; $display("FAIL rst_ack pre-reset ack/doe/dout: got %h expected %h", {acked, bus.DOE, bus.D_out}, {1'b1, 1'b1, 16'h1357});
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.DTACK_b, bus.DOE, bus.D_out} !== {1'b1, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL rst_ack immediate dtack/doe/dout: got %h expected %h", {bus.DTACK_b, bus.DOE, bus.D_out}, {1'b1, 1'b0, 16'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_idle();
    @(negedge clk);
    cpu_cycle(23'h000ABC, 16'h0F0F, 1'b0, 1'b1, 1'b0, 0, "after_reset_write");
  endtask

  task automatic test_back_to_back();
    int ns = 0, nd = 0;
    cpu_cycle(23'h000010, 16'h1234, 1'b0, 1'b0, 1'b0, 0, "b2b_first");
    cpu_cycle(23'h000FFF, 16'h00A5, 1'b1, 1'b0, 1'b0, 0, "b2b_second");
    // Deselected cycle: nothing may respond.
    bus.A = 23'h000020; bus.UDS_b = 1'b0; bus.LDS_b = 1'b0; bus.R_b_Vs_W = WRITE;
    bus.SEL_b = 1'b1; bus.AS_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.MEM_WE_H | bus.MEM_WE_L | bus.MEM_RE) ns++;
      if (!bus.DTACK_b) nd++;
    end
    n_checks++;
    if ({ns, nd} !== 64'd0) begin n_fail++; $display("FAIL sel_b_high strobes/dtack: got %0d/%0d expected 0/0", ns, nd); end
    bus_idle();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_read();
    test_vid_slot();
    test_abort_arb();
    test_reset_in_ack();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
